// File: rtl/reset_sequencer.sv
// reset_sequencer: power-on delay, stretched reset, then staggered release of
// NUM_CHANNELS active-high reset domains. A synchronised command strobe or the
// sw_hold level sends the sequencer back into the stretch phase.
module reset_sequencer #(
  parameter int SYNC_STAGES    = 2,
  parameter int POR_CYCLES     = 4,
  parameter int STRETCH_CYCLES = 8,
  parameter int NUM_CHANNELS   = 3,
  parameter int STAGGER_CYCLES = 4
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic                    cmd_reset_strobe,
  input  logic                    sw_hold,
  output logic [NUM_CHANNELS-1:0] reset_out,
  output logic                    all_released,
  output logic                    busy,
  output logic [7:0]              reset_count
);

  // The counter must reach the longest phase length and the offset of the last channel release
  localparam int REL_SPAN = STAGGER_CYCLES * (NUM_CHANNELS - 1);
  localparam int MAX_PS   = (POR_CYCLES > STRETCH_CYCLES) ? POR_CYCLES : STRETCH_CYCLES;
  localparam int MAX_CNT  = (MAX_PS > REL_SPAN) ? MAX_PS : REL_SPAN;
  localparam int CNT_W    = $clog2(MAX_CNT + 1);

  typedef enum logic [1:0] {
    ST_POR,
    ST_STRETCH,
    ST_RELEASE,
    ST_RUN
  } state_t;

  state_t                  state;
  logic [CNT_W-1:0]        cnt;
  logic [CNT_W-1:0]        cnt_next;
  logic [SYNC_STAGES-1:0]  sync_q;
  logic                    cmd_prev;
  logic                    cmd_rise;

  assign cnt_next = cnt + 1'b1;
  assign cmd_rise = sync_q[SYNC_STAGES-1] & ~cmd_prev;

  // Command synchroniser chain plus one flop that remembers the last synchronised level
  always_ff @(posedge clk) begin
    if (!resetn) begin
      sync_q   <= '0;
      cmd_prev <= 1'b0;
    end else begin
      sync_q   <= {sync_q[SYNC_STAGES-2:0], cmd_reset_strobe};
      cmd_prev <= sync_q[SYNC_STAGES-1];
    end
  end

  // Sequencer FSM with all outputs registered alongside the state
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state        <= ST_POR;
      cnt          <= '0;
      reset_out    <= '1;
      all_released <= 1'b0;
      busy         <= 1'b1;
      reset_count  <= 8'd0;
    end else if (state == ST_POR) begin
      if (cnt == CNT_W'(POR_CYCLES - 1)) begin
        state <= ST_STRETCH;
        cnt   <= '0;
      end else begin
        cnt <= cnt_next;
      end
    end else if (cmd_rise || sw_hold) begin
      state        <= ST_STRETCH;
      cnt          <= '0;
      reset_out    <= '1;
      all_released <= 1'b0;
      busy         <= 1'b1;
      if (cmd_rise && (reset_count != 8'hFF)) begin
        reset_count <= reset_count + 8'd1;
      end
    end else begin
      case (state)
        ST_STRETCH: begin
          if (cnt == CNT_W'(STRETCH_CYCLES - 1)) begin
            cnt       <= '0;
            reset_out <= ~NUM_CHANNELS'(1);
            if (NUM_CHANNELS == 1) begin
              state        <= ST_RUN;
              all_released <= 1'b1;
              busy         <= 1'b0;
            end else begin
              state <= ST_RELEASE;
            end
          end else begin
            cnt <= cnt_next;
          end
        end
        ST_RELEASE: begin
          cnt <= cnt_next;
          for (int i = 1; i < NUM_CHANNELS; i++) begin
            if (cnt_next == CNT_W'(i * STAGGER_CYCLES)) begin
              reset_out[i] <= 1'b0;
            end
          end
          if (cnt_next == CNT_W'(REL_SPAN)) begin
            state        <= ST_RUN;
            all_released <= 1'b1;
            busy         <= 1'b0;
          end
        end
        default: begin
          cnt <= '0;
        end
      endcase
    end
  end

endmodule
